// File: rtl/mux2_rr_arbiter_pkg.sv
// ============================================================================
// mux2_rr_pkg : shared states, source ids and counter sizing for mux2_rr_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mux2_rr_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t GNT_A = 2'd1;
  localparam state_t GNT_B = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Burst counter must be able to hold MAX_BURST itself.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux2_rr_arbiter_if.sv
// ============================================================================
// mux2_rr_arbiter_if : two valid/ready sources, one registered output, select
// Rev 1.0
// ============================================================================
`default_nettype none

interface mux2_rr_arbiter_if #(
  parameter int W = 8
);

  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic         y_valid;
  logic [W-1:0] y_data;
  logic         y_src;
  logic         y_ready;
  logic         sel;

  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, y_src, sel
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, y_src, sel
  );

endinterface

`default_nettype wire

// File: rtl/mux2_rr_arbiter_out_reg.sv
// ============================================================================
// mux2_out_reg : single-entry valid/ready output register
// Rev 1.0
// ============================================================================
`default_nettype none

module mux2_out_reg #(
  parameter int PW = 9
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_load,
  input  wire logic [PW-1:0] i_data,
  input  wire logic          i_ready,
  output logic               o_valid,
  output logic [PW-1:0]      o_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;

  // Payload is only written on a load, so it holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// mux2_rr_arbiter : round-robin burst arbiter fused with a registered 2:1 mux
// Rev 1.0
// ============================================================================
`default_nettype none

module mux2_rr_arbiter
  import mux2_rr_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  mux2_rr_arbiter_if.slave  bus
);

  localparam int            CW           = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] C_BURST_LAST = CW'(MAX_BURST);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_prio;
  logic          w_prio_nxt;
  logic          r_sel;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;

  logic          w_load_en;
  logic          w_a_xfer;
  logic          w_b_xfer;
  logic          w_xfer;
  logic          w_grant_src;
  logic          w_gnt_valid;
  logic          w_other_valid;
  logic          w_y_valid;
  logic [W:0]    w_y_payload;
  logic [W:0]    w_xfer_payload;

  assign w_load_en     = !w_y_valid || bus.y_ready;
  assign bus.a_ready   = (r_state == GNT_A) && w_load_en;
  assign bus.b_ready   = (r_state == GNT_B) && w_load_en;
  assign w_a_xfer      = bus.a_valid && bus.a_ready;
  assign w_b_xfer      = bus.b_valid && bus.b_ready;
  assign w_xfer        = w_a_xfer || w_b_xfer;
  assign w_grant_src   = (r_state == GNT_B) ? SRC_B : SRC_A;
  assign w_gnt_valid   = (w_grant_src == SRC_B) ? bus.b_valid : bus.a_valid;
  assign w_other_valid = (w_grant_src == SRC_B) ? bus.a_valid : bus.b_valid;
  assign w_cnt_inc     = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (bus.a_valid && bus.b_valid) begin
          w_state_nxt = (r_prio == SRC_B) ? GNT_B : GNT_A;
        end else if (bus.a_valid) begin
          w_state_nxt = GNT_A;
        end else if (bus.b_valid) begin
          w_state_nxt = GNT_B;
        end
      end
      GNT_A, GNT_B: begin
        // Release on burst end or when the owner goes idle; a stall never releases.
        if (!w_gnt_valid || (w_xfer && (w_cnt_inc == C_BURST_LAST))) begin
          if (w_other_valid) begin
            w_state_nxt = (w_grant_src == SRC_B) ? GNT_A : GNT_B;
          end else begin
            w_state_nxt = IDLE;
          end
          w_prio_nxt = !w_grant_src;
          w_cnt_nxt  = '0;
        end else if (w_xfer) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= SRC_A;
      r_cnt   <= '0;
      r_sel   <= SRC_A;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_state_nxt == GNT_A) begin
        r_sel <= SRC_A;
      end else if (w_state_nxt == GNT_B) begin
        r_sel <= SRC_B;
      end
    end
  end

  assign bus.sel        = r_sel;
  assign w_xfer_payload = (w_grant_src == SRC_B) ? {SRC_B, bus.b_data} : {SRC_A, bus.a_data};

  mux2_out_reg #(
    .PW (W + 1)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_xfer),
    .i_data  (w_xfer_payload),
    .i_ready (bus.y_ready),
    .o_valid (w_y_valid),
    .o_data  (w_y_payload)
  );

  assign bus.y_valid = w_y_valid;
  assign bus.y_src   = w_y_payload[W];
  assign bus.y_data  = w_y_payload[W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// tb_mux2_rr_arbiter : directed bench, DUTs with MAX_BURST 4/2/1, scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic [2:0]      a_v, b_v, y_r;
  logic [2:0][7:0] a_d, b_d;
  logic [2:0]      a_r, b_r, y_v, y_s, sel;
  logic [2:0][7:0] y_d;

  int checks = 0;
  int errors = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int MB = (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    mux2_rr_arbiter_if #(.W(8)) bus ();
    assign bus.a_valid = a_v[k];
    assign bus.a_data  = a_d[k];
    assign bus.b_valid = b_v[k];
    assign bus.b_data  = b_d[k];
    assign bus.y_ready = y_r[k];
    assign a_r[k]      = bus.a_ready;
    assign b_r[k]      = bus.b_ready;
    assign y_v[k]      = bus.y_valid;
    assign y_d[k]      = bus.y_data;
    assign y_s[k]      = bus.y_src;
    assign sel[k]      = bus.sel;
    mux2_rr_arbiter #(
      .W         (8),
      .MAX_BURST (MB)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic src, input logic [7:0] d);
    case (k)
      0:       q0.push_back({src, d});
      1:       q1.push_back({src, d});
      default: q2.push_back({src, d});
    endcase
  endtask

  task automatic pop_cmp(input int k, input logic [8:0] act);
    logic [8:0] e;
    int n;
    case (k)
      0:       n = q0.size();
      1:       n = q1.size();
      default: n = q2.size();
    endcase
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL sb%0d beat: got %0h expected none", k, act);
    end else begin
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("sb%0d beat", k), 32'(act), 32'(e));
    end
  endtask

  // Monitor: a beat leaves y on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (y_v[k] && y_r[k]) pop_cmp(k, {y_s[k], y_d[k]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic run_both(input int k, input logic [5:0] pat);
    logic [7:0] na, nb;
    logic ha, hb;
    na = 8'hA0;
    nb = 8'hB0;
    for (int i = 0; i < 6; i++) begin
      if (pat[i]) begin push(k, 1'b1, nb); nb = nb + 8'd1; end
      else        begin push(k, 1'b0, na); na = na + 8'd1; end
    end
    step; a_v[k] = 1'b1; b_v[k] = 1'b1; a_d[k] = 8'hA0; b_d[k] = 8'hB0;
    mid;  chk($sformatf("both%0d arb cycle readies", k), {a_r[k], b_r[k]}, 0);
    ha = 1'b0;
    hb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (ha) a_d[k] = a_d[k] + 8'd1;
      if (hb) b_d[k] = b_d[k] + 8'd1;
      mid;
      chk($sformatf("both%0d sel c%0d", k, i + 1), sel[k], pat[i]);
      chk($sformatf("both%0d no bubble c%0d", k, i + 1), a_r[k] | b_r[k], 1);
      ha = a_v[k] && a_r[k];
      hb = b_v[k] && b_r[k];
    end
    step; a_v[k] = 1'b0; b_v[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_v = '0; b_v = '0; a_d = '0; b_d = '0; y_r = 3'b111;
    step; step;
    mid;
    chk("rst y_valid", y_v, 0);
    chk("rst a_ready", a_r, 0);
    chk("rst b_ready", b_r, 0);
    chk("rst sel", sel, 0);
    chk("rst y_data0", y_d[0], 0);
    step; rst = 1'b0;

    // A only, MAX_BURST=4
    push(0, 1'b0, 8'h11); push(0, 1'b0, 8'h22); push(0, 1'b0, 8'h33);
    step; a_v[0] = 1'b1; a_d[0] = 8'h11;
    mid;  chk("t1 idle a_ready", a_r[0], 0);
    step; mid;
    chk("t1 a_ready", a_r[0], 1);
    chk("t1 y_valid early", y_v[0], 0);
    chk("t1 sel", sel[0], 0);
    step; a_d[0] = 8'h22;
    mid;  chk("t1 y_valid", y_v[0], 1); chk("t1 y_data0", y_d[0], 8'h11); chk("t1 y_src", y_s[0], 0);
    step; a_d[0] = 8'h33;
    mid;  chk("t1 y_data1", y_d[0], 8'h22);
    step; a_v[0] = 1'b0;
    mid;  chk("t1 y_data2", y_d[0], 8'h33);
    step; mid;
    chk("t1 back idle a_ready", a_r[0], 0);
    chk("t1 y drained", y_v[0], 0);

    // Back-pressure then burst yield with one bubble
    push(0, 1'b0, 8'h5A); push(0, 1'b0, 8'h5B); push(0, 1'b0, 8'h5C);
    push(0, 1'b0, 8'h5D); push(0, 1'b0, 8'h5E);
    step; a_v[0] = 1'b1; a_d[0] = 8'h5A;
    mid;  chk("t3 idle a_ready", a_r[0], 0);
    step; mid; chk("t3 a_ready", a_r[0], 1);
    step; a_d[0] = 8'h5B; y_r[0] = 1'b0;
    mid;  chk("t3 stall y_data", y_d[0], 8'h5A); chk("t3 stall a_ready", a_r[0], 0);
    step; mid;
    chk("t3 stall y_valid", y_v[0], 1); chk("t3 stall y_data b", y_d[0], 8'h5A); chk("t3 stall a_ready b", a_r[0], 0);
    step; mid; chk("t3 stall y_data c", y_d[0], 8'h5A);
    step; y_r[0] = 1'b1;
    mid;  chk("t3 resume a_ready", a_r[0], 1);
    step; a_d[0] = 8'h5C; mid; chk("t3 y_data 5B", y_d[0], 8'h5B);
    step; a_d[0] = 8'h5D; mid; chk("t3 y_data 5C", y_d[0], 8'h5C);
    step; a_d[0] = 8'h5E;
    mid;  chk("t3 yield bubble a_ready", a_r[0], 0); chk("t3 y_data 5D", y_d[0], 8'h5D);
    step; mid; chk("t3 regrant a_ready", a_r[0], 1);
    step; a_v[0] = 1'b0; mid; chk("t3 y_data 5E", y_d[0], 8'h5E);
    step;

    // Both valid: MAX_BURST=2 gives A,A,B,B,A,A; MAX_BURST=1 alternates
    run_both(1, 6'b001100);
    run_both(2, 6'b101010);

    // Async reset mid-burst with B owning the path and a beat held in y
    step; b_v[0] = 1'b1; b_d[0] = 8'hC1;
    mid;  chk("t5 idle b_ready", b_r[0], 0);
    step; mid; chk("t5 sel B", sel[0], 1); chk("t5 b_ready", b_r[0], 1);
    step; b_v[0] = 1'b0; y_r[0] = 1'b0;
    mid;  chk("t5 y_valid held", y_v[0], 1); chk("t5 y_src B", y_s[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("t5 async y_valid", y_v[0], 0);
    chk("t5 async a_ready", a_r[0], 0);
    chk("t5 async b_ready", b_r[0], 0);
    chk("t5 async sel", sel[0], 0);
    push(0, 1'b0, 8'hD1);
    step; rst = 1'b0; y_r[0] = 1'b1;
    a_v[0] = 1'b1; b_v[0] = 1'b1; a_d[0] = 8'hD1; b_d[0] = 8'hE1;
    mid;  chk("t5 post-rst idle readies", {a_r[0], b_r[0]}, 0);
    step; mid;
    chk("t5 first grant sel", sel[0], 0); chk("t5 first grant a_ready", a_r[0], 1); chk("t5 first grant b_ready", b_r[0], 0);
    step; a_v[0] = 1'b0; b_v[0] = 1'b0;
    mid;  chk("t5 y_data D1", y_d[0], 8'hD1); chk("t5 y_src A", y_s[0], 0);
    step;

    // B releases by dropping valid while A waits
    push(0, 1'b1, 8'hF1); push(0, 1'b0, 8'h71);
    step; b_v[0] = 1'b1; b_d[0] = 8'hF1;
    mid;  chk("t6 idle b_ready", b_r[0], 0);
    step; mid; chk("t6 b_ready", b_r[0], 1); chk("t6 sel B", sel[0], 1);
    step; b_v[0] = 1'b0; a_v[0] = 1'b1; a_d[0] = 8'h71;
    mid;  chk("t6 release sel", sel[0], 1); chk("t6 release a_ready", a_r[0], 0);
    step; mid; chk("t6 switch sel", sel[0], 0); chk("t6 switch a_ready", a_r[0], 1);
    step; a_v[0] = 1'b0;
    mid;  chk("t6 y_valid", y_v[0], 1); chk("t6 y_data", y_d[0], 8'h71); chk("t6 y_src", y_s[0], 0);

    step; step; step;
    chk("sb0 drained", q0.size(), 0);
    chk("sb1 drained", q1.size(), 0);
    chk("sb2 drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
